// File: rtl/fill_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fill_pattern_gen
//  Function : Sequential source of width-cast fill words. For every cast
//             width W = STEP, 2*STEP, ..., WIDTH it emits W'('0) and then
//             W'('1), zero-extended to WIDTH bits. Each word goes out on a
//             valid/ready handshake together with its cast width, its fill
//             kind and a last-word flag.
//  Revision : 1.0 - initial release
// ============================================================================
module fill_pattern_gen #(
    parameter int WIDTH = 64,
    parameter int STEP  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(WIDTH+1)-1:0] out_width,
    output logic                       out_kind,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               c_ww    = $clog2(WIDTH + 1);
    localparam logic [c_ww-1:0]  c_width = c_ww'(WIDTH);
    localparam logic [c_ww-1:0]  c_step  = c_ww'(STEP);
    localparam logic [WIDTH-1:0] c_ones  = {WIDTH{1'b1}};

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("fill_pattern_gen: WIDTH must be at least 1");
        end
        if (STEP < 1) begin : g_bad_step
            $error("fill_pattern_gen: STEP must be at least 1");
        end else if ((WIDTH % STEP) != 0) begin : g_bad_divisor
            $error("fill_pattern_gen: STEP must divide WIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_ww-1:0]   r_width;
    logic [c_ww-1:0]   w_width_nxt;
    logic              r_kind;
    logic              w_kind_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic [WIDTH-1:0]  r_data;
    logic [WIDTH-1:0]  w_data_nxt;

    // ------------------------------------------------------------------------
    // Low-W-bits mask. Shifting an all-ones word down by (WIDTH - W) never
    // needs a bit above WIDTH, so W = WIDTH yields all ones without the
    // overflow that (1 << WIDTH) - 1 would suffer in a WIDTH-bit expression.
    // ------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] f_mask(input logic [c_ww-1:0] w);
        logic [c_ww-1:0] sh;
        sh = c_width - w;
        if (w == '0) begin
            f_mask = '0;
        end else begin
            f_mask = c_ones >> sh;
        end
    endfunction

    // ------------------------------------------------------------------------
    // Next-state and next-word selection
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_width_nxt = r_width;
        w_kind_nxt  = r_kind;
        w_last_nxt  = r_last;
        w_data_nxt  = r_data;

        case (r_state)
            // IDLE and DONE behave the same: wait for start, then load the
            // first word (W = STEP, kind 0). DONE keeps the last word visible.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_width_nxt = c_step;
                    w_kind_nxt  = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_data_nxt  = '0;
                end
            end

            // Advance only on a transfer; start is deliberately not looked at
            // here, so a start that coincides with the last transfer is lost.
            ST_RUN: begin
                if (out_ready) begin
                    if (r_last) begin
                        w_state_nxt = ST_DONE;
                    end else if (!r_kind) begin
                        w_kind_nxt = 1'b1;
                        w_last_nxt = (r_width == c_width);
                        w_data_nxt = f_mask(r_width);
                    end else begin
                        w_width_nxt = r_width + c_step;
                        w_kind_nxt  = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_data_nxt  = '0;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output-word registers; reset dominates start.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_width <= '0;
            r_kind  <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_width <= w_width_nxt;
            r_kind  <= w_kind_nxt;
            r_last  <= w_last_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: everything comes straight from registers, so the word is
    // glitch-free at the edge and frozen during a stall.
    // ------------------------------------------------------------------------
    assign out_valid = (r_state == ST_RUN);
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign out_data  = r_data;
    assign out_width = r_width;
    assign out_kind  = r_kind;
    assign out_last  = r_last;

endmodule
`default_nettype wire
